load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 31 +++
 rtl/load_store_unit.sv | 139 +++++++++++++
 tb/tb_load_store_unit.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core request/response and memory-side signals of the load/store unit
interface load_store_unit_if #(
  parameter int W = 32,
  parameter int N = 5
);
  logic         req_valid;
  logic         req_ready;
  logic         req_write;
  logic [1:0]   req_size;
  logic         req_unsigned;
  logic [N+1:0] req_addr;
  logic [W-1:0] req_wdata;
  logic         resp_valid;
  logic         resp_err;
  logic [W-1:0] resp_rdata;
  logic [N-1:0] address;
  logic         MemRead;
  logic         MemWrite;
  logic [W-1:0] write_data;
  logic [W-1:0] read_data;

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, read_data,
    output req_ready, resp_valid, resp_err, resp_rdata, address, MemRead, MemWrite, write_data
  );

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata, read_data,
    input  req_ready, resp_valid, resp_err, resp_rdata, address, MemRead, MemWrite, write_data
  );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with byte/half read-modify-write
module load_store_unit #(
  parameter int W = 32,
  parameter int N = 5
) (
  input  logic              clk,
  input  logic              rst,
  load_store_unit_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, RD, CAPT, WR, RESP} state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t       state_q, state_d;
  logic         write_q, write_d;
  logic [1:0]   size_q, size_d;
  logic         uns_q, uns_d;
  logic [N+1:0] addr_q, addr_d;
  logic [W-1:0] wdata_q, wdata_d;
  logic [W-1:0] word_q, word_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic         err_q, err_d;

  logic         bad_req;
  logic [W-1:0] merged;
  logic [W-1:0] shifted;
  logic [W-1:0] extracted;

  assign bad_req = (bus.req_size == 2'b11)
                || (bus.req_size == SZ_HALF && bus.req_addr[0])
                || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00);

  // Store word: the captured memory word with only the addressed lane(s) replaced.
  always_comb begin
    merged = word_q;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = wdata_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  always_comb begin
    shifted = bus.read_data >> {addr_q[1:0], 3'b000};
    case (size_q)
      SZ_BYTE: extracted = uns_q ? {{(W-8){1'b0}}, shifted[7:0]}
                                 : {{(W-8){shifted[7]}}, shifted[7:0]};
      SZ_HALF: extracted = uns_q ? {{(W-16){1'b0}}, shifted[15:0]}
                                 : {{(W-16){shifted[15]}}, shifted[15:0]};
      default: extracted = bus.read_data;
    endcase
  end

  always_comb begin
    state_d = state_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (bad_req) begin
            err_d   = 1'b1;
            rdata_d = '0;
            state_d = RESP;
          end else if (bus.req_write && bus.req_size == SZ_WORD) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      RD: state_d = CAPT;
      CAPT: begin
        // Loads finish here; sub-word stores keep the word for the merge in WR.
        word_d = bus.read_data;
        if (write_q) begin
          state_d = WR;
        end else begin
          rdata_d = extracted;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      WR: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.address    = addr_q[N+1:2];
  assign bus.MemRead    = (state_q == RD);
  assign bus.MemWrite   = (state_q == WR);
  assign bus.write_data = (state_q == WR) ? merged : '0;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  localparam int W = 32;
  localparam int N = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if #(.W(W), .N(N)) bus ();

  load_store_unit #(.W(W), .N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [W-1:0] mem [0:(1<<N)-1];
  logic [W-1:0] rd_q = '0;
  int wr_cnt = 0;
  int resp_cnt = 0;

  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.address] <= bus.write_data;
    if (bus.MemRead) rd_q <= mem[bus.address];
    if (bus.MemWrite) wr_cnt <= wr_cnt + 1;
    if (bus.resp_valid) resp_cnt <= resp_cnt + 1;
  end
  assign bus.read_data = rd_q;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Accept happens at the posedge ending cycle T; returns at the negedge of T+1.
  task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [N+1:0] addr, input logic [W-1:0] wd);
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    check("ready_at_T", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_valid    = 1'b0;
    bus.req_write    = ~wr;
    bus.req_unsigned = ~uns;
    bus.req_addr     = ~addr;
    bus.req_wdata    = 32'hA5A5_A5A5;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
    check({tag, "_rvalid"}, {31'b0, bus.resp_valid}, 32'd0);
    check({tag, "_err"}, {31'b0, bus.resp_err}, 32'd0);
    check({tag, "_rdata"}, bus.resp_rdata, 32'd0);
    check({tag, "_mrd"}, {31'b0, bus.MemRead}, 32'd0);
    check({tag, "_mwr"}, {31'b0, bus.MemWrite}, 32'd0);
    check({tag, "_addr"}, {27'b0, bus.address}, 32'd0);
    check({tag, "_wdata"}, bus.write_data, 32'd0);
  endtask

  task automatic error_case(input string tag, input logic [1:0] sz, input logic [N+1:0] addr);
    issue(1'b0, sz, 1'b0, addr, 32'h0);
    check({tag, "_rvalid"}, {31'b0, bus.resp_valid}, 32'd1);
    check({tag, "_err"}, {31'b0, bus.resp_err}, 32'd1);
    check({tag, "_rdata"}, bus.resp_rdata, 32'd0);
    check({tag, "_mem"}, {30'b0, bus.MemRead, bus.MemWrite}, 32'd0);
    @(negedge clk);
    check({tag, "_ready_after"}, {31'b0, bus.req_ready}, 32'd1);
    check({tag, "_err_hold"}, {31'b0, bus.resp_err}, 32'd1);
  endtask

  task automatic load_case(input string tag, input logic [1:0] sz, input logic uns,
                           input logic [N+1:0] addr, input logic [W-1:0] exp);
    issue(1'b0, sz, uns, addr, 32'h0);
    check({tag, "_mrd_T1"}, {31'b0, bus.MemRead}, 32'd1);
    @(negedge clk);
    check({tag, "_mrd_T2"}, {31'b0, bus.MemRead}, 32'd0);
    @(negedge clk);
    check({tag, "_rvalid_T3"}, {31'b0, bus.resp_valid}, 32'd1);
    check({tag, "_rdata"}, bus.resp_rdata, exp);
    check({tag, "_err"}, {31'b0, bus.resp_err}, 32'd0);
    @(negedge clk);
  endtask

  int wr_snap;
  int resp_snap;

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b00;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    for (int i = 0; i < (1 << N); i++) mem[i] = '0;
    mem[1] = 32'h1122_3344;
    mem[3] = 32'h0BAD_F00D;
    mem[4] = 32'hCAFE_F00D;

    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst = 1'b0;

    // Word store
    issue(1'b1, 2'b10, 1'b0, 7'h08, 32'hDEAD_BEEF);
    check("ws_mwr_T1", {31'b0, bus.MemWrite}, 32'd1);
    check("ws_mrd_T1", {31'b0, bus.MemRead}, 32'd0);
    check("ws_addr_T1", {27'b0, bus.address}, 32'd2);
    check("ws_wdata_T1", bus.write_data, 32'hDEAD_BEEF);
    @(negedge clk);
    check("ws_rvalid_T2", {31'b0, bus.resp_valid}, 32'd1);
    check("ws_err_T2", {31'b0, bus.resp_err}, 32'd0);
    check("ws_mwr_T2", {31'b0, bus.MemWrite}, 32'd0);
    @(negedge clk);
    check("ws_rvalid_T3", {31'b0, bus.resp_valid}, 32'd0);
    check("ws_mem2", mem[2], 32'hDEAD_BEEF);

    load_case("lb_s", 2'b00, 1'b0, 7'h09, 32'hFFFF_FFBE);
    check("lb_s_hold", bus.resp_rdata, 32'hFFFF_FFBE);
    load_case("lb_u", 2'b00, 1'b1, 7'h09, 32'h0000_00BE);
    load_case("lw", 2'b10, 1'b0, 7'h08, 32'hDEAD_BEEF);

    // Half store read-modify-write
    issue(1'b1, 2'b01, 1'b0, 7'h0A, 32'hFFFF_1234);
    check("hs_mrd_T1", {31'b0, bus.MemRead}, 32'd1);
    check("hs_mwr_T1", {31'b0, bus.MemWrite}, 32'd0);
    @(negedge clk);
    check("hs_mem_T2", {30'b0, bus.MemRead, bus.MemWrite}, 32'd0);
    @(negedge clk);
    check("hs_mwr_T3", {31'b0, bus.MemWrite}, 32'd1);
    check("hs_wdata_T3", bus.write_data, 32'h1234_BEEF);
    check("hs_addr_T3", {27'b0, bus.address}, 32'd2);
    @(negedge clk);
    check("hs_rvalid_T4", {31'b0, bus.resp_valid}, 32'd1);
    check("hs_rdata_T4", bus.resp_rdata, 32'd0);
    @(negedge clk);
    check("hs_mem2", mem[2], 32'h1234_BEEF);

    load_case("lh_s", 2'b01, 1'b0, 7'h08, 32'hFFFF_BEEF);
    load_case("lh_u", 2'b01, 1'b1, 7'h0A, 32'h0000_1234);

    // Byte store into top lane
    issue(1'b1, 2'b00, 1'b0, 7'h0B, 32'h0000_0077);
    @(negedge clk);
    @(negedge clk);
    check("bs_mwr_T3", {31'b0, bus.MemWrite}, 32'd1);
    check("bs_wdata_T3", bus.write_data, 32'h7734_BEEF);
    @(negedge clk);
    check("bs_rvalid_T4", {31'b0, bus.resp_valid}, 32'd1);
    @(negedge clk);
    load_case("lb_top", 2'b00, 1'b0, 7'h0B, 32'h0000_0077);

    error_case("err_lw06", 2'b10, 7'h06);
    error_case("err_sz11", 2'b11, 7'h00);
    error_case("err_lh01", 2'b01, 7'h01);

    // Reset while a byte store is in CAPT
    issue(1'b1, 2'b00, 1'b0, 7'h04, 32'h0000_0055);
    @(negedge clk);
    wr_snap   = wr_cnt;
    resp_snap = resp_cnt;
    rst = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_size  = 2'b10;
    bus.req_addr  = 7'h0C;
    #1;
    check_reset_outputs("rst_mid");
    @(negedge clk);
    @(negedge clk);
    check("rst_hold_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_hold_mrd", {31'b0, bus.MemRead}, 32'd0);
    rst = 1'b0;
    bus.req_valid = 1'b0;
    #1;
    check_reset_outputs("rst_after");
    repeat (5) @(negedge clk);
    check("rst_no_write", wr_cnt, wr_snap);
    check("rst_no_resp", resp_cnt, resp_snap);
    check("rst_mem1", mem[1], 32'h1122_3344);
    check("rst_idle_ready", {31'b0, bus.req_ready}, 32'd1);

    // Back-to-back word loads with req_valid held high
    @(negedge clk);
    bus.req_valid    = 1'b1;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'b10;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 7'h0C;
    check("b2b_ready_c0", {31'b0, bus.req_ready}, 32'd1);
    @(negedge clk);
    bus.req_addr = 7'h10;
    check("b2b_ready_c1", {31'b0, bus.req_ready}, 32'd0);
    check("b2b_addr_c1", {27'b0, bus.address}, 32'd3);
    @(negedge clk);
    check("b2b_ready_c2", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    check("b2b_ready_c3", {31'b0, bus.req_ready}, 32'd0);
    check("b2b_rvalid_c3", {31'b0, bus.resp_valid}, 32'd1);
    check("b2b_rdata1", bus.resp_rdata, 32'h0BAD_F00D);
    @(negedge clk);
    check("b2b_ready_c4", {31'b0, bus.req_ready}, 32'd1);
    check("b2b_rvalid_c4", {31'b0, bus.resp_valid}, 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("b2b_ready_c5", {31'b0, bus.req_ready}, 32'd0);
    check("b2b_mrd_c5", {31'b0, bus.MemRead}, 32'd1);
    check("b2b_addr_c5", {27'b0, bus.address}, 32'd4);
    @(negedge clk);
    @(negedge clk);
    check("b2b_rvalid_c7", {31'b0, bus.resp_valid}, 32'd1);
    check("b2b_rdata2", bus.resp_rdata, 32'hCAFE_F00D);
    @(negedge clk);
    check("b2b_idle", {31'b0, bus.req_ready}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
